// File: rtl/goertzel_pkg.sv
// Shared definitions for the Goertzel bin sequencer and its helpers.
// Holds the sequencer state encoding, the default block and pipeline sizes, the
// datapath word width used by the surrounding arithmetic, and a width helper.
package goertzel_pkg;

    localparam int unsigned N_SAMPLES_DEF = 205;
    localparam int unsigned CNT_W_DEF     = 8;
    localparam int unsigned MUL_LAT_DEF   = 2;
    // Datapath word width (s1/s2/adder); only the datapath uses it.
    localparam int unsigned W             = 61;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StClr  = 3'd1,
        StWait = 3'd2,
        StMul  = 3'd3,
        StAdd  = 3'd4,
        StUpd  = 3'd5,
        StDone = 3'd6
    } seq_state_e;

    // Bits needed for a down-counter loaded with lat-1; at least one bit.
    function automatic int unsigned lat_width(input int unsigned lat);
        int unsigned w;
        w = (lat > 1) ? $clog2(lat) : 1;
        return w;
    endfunction

endpackage

// File: rtl/goertzel_seq_ctrl_if.sv
// Control/handshake bundle between the Goertzel sequencer and its datapath.
// slave  : the sequencer (takes start/abort/smp_valid/res_ready, drives the rest)
// master : the block that drives the sequencer (datapath wrapper or bench)
// Signals: start, abort, smp_valid/smp_ready, x_ld, st_clr, mul_en, add_en, st_upd,
//          busy, smp_cnt[CNT_W], res_valid/res_ready.
interface goertzel_seq_ctrl_if
    import goertzel_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) ();

    logic             start;
    logic             abort;
    logic             smp_valid;
    logic             smp_ready;
    logic             x_ld;
    logic             st_clr;
    logic             mul_en;
    logic             add_en;
    logic             st_upd;
    logic             busy;
    logic [CNT_W-1:0] smp_cnt;
    logic             res_valid;
    logic             res_ready;

    modport master (
        output start, abort, smp_valid, res_ready,
        input  smp_ready, x_ld, st_clr, mul_en, add_en, st_upd, busy, smp_cnt, res_valid
    );

    modport slave (
        input  start, abort, smp_valid, res_ready,
        output smp_ready, x_ld, st_clr, mul_en, add_en, st_upd, busy, smp_cnt, res_valid
    );

endinterface

// File: rtl/goertzel_lat_timer.sv
// Loadable down-counter that flags completion of a fixed-latency pipelined unit.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset (count -> 0)
//   load      : load load_val (wins over en)
//   load_val  : latency minus one
//   en        : unit is being stepped this cycle; counter decrements while nonzero
//   done      : en is high and the count has reached zero (last enabled cycle)
module goertzel_lat_timer #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             done
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = en && (cnt_q == '0);

endmodule

// File: rtl/goertzel_seq_ctrl.sv
// Control sequencer for one Goertzel bin: s[n] = x[n] + coeff*s[n-1] - s[n-2].
// Takes samples over smp_valid/smp_ready, steps the multiplier for MUL_LAT cycles,
// pulses the registered adder once, then updates s1/s2. After N_SAMPLES iterations
// it holds res_valid until res_ready. No arithmetic lives here.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : goertzel_seq_ctrl_if.slave (start, abort, sample and result handshakes,
//              datapath enables, busy, smp_cnt)
// Every output is decoded from registered state/counters; only x_ld also looks at smp_valid.
module goertzel_seq_ctrl
    import goertzel_pkg::*;
#(
    parameter int unsigned N_SAMPLES = N_SAMPLES_DEF,
    parameter int unsigned CNT_W     = CNT_W_DEF,
    parameter int unsigned MUL_LAT   = MUL_LAT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    goertzel_seq_ctrl_if.slave bus
);

    localparam int unsigned      LAT_W    = lat_width(MUL_LAT);
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MUL_LAT - 1);
    // Count value seen in UPD of the final sample; compared before the increment so
    // N_SAMPLES = 2**CNT_W still terminates.
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_SAMPLES - 1);

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic smp_ready;
    logic x_ld;
    logic st_clr;
    logic mul_en;
    logic add_en;
    logic st_upd;
    logic busy;
    logic res_valid;
    logic lat_done;

    // Multiplier latency timer: armed when a sample is taken, stepped by mul_en.
    goertzel_lat_timer #(
        .WIDTH (LAT_W)
    ) u_lat_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (x_ld),
        .load_val (LAT_LOAD),
        .en       (mul_en),
        .done     (lat_done)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state. abort overrides everything, including start in IDLE.
    always_comb begin
        state_d = state_q;
        if (bus.abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: if (bus.start)     state_d = StClr;
                StClr:                     state_d = StWait;
                StWait: if (bus.smp_valid) state_d = StMul;
                StMul:  if (lat_done)      state_d = StAdd;
                StAdd:                     state_d = StUpd;
                StUpd:  state_d = (cnt_q == LAST_IDX) ? StDone : StWait;
                StDone: if (bus.res_ready) state_d = StIdle;
                default:                   state_d = StIdle;
            endcase
        end
    end

    // Outputs decoded from the registered state.
    always_comb begin
        smp_ready = 1'b0;
        st_clr    = 1'b0;
        mul_en    = 1'b0;
        add_en    = 1'b0;
        st_upd    = 1'b0;
        res_valid = 1'b0;
        busy      = (state_q != StIdle);
        unique case (state_q)
            StClr:   st_clr    = 1'b1;
            StWait:  smp_ready = 1'b1;
            StMul:   mul_en    = 1'b1;
            StAdd:   add_en    = 1'b1;
            StUpd:   st_upd    = 1'b1;
            StDone:  res_valid = 1'b1;
            default: ;
        endcase
    end

    assign x_ld = bus.smp_valid & smp_ready;

    // Sample counter. An abort mid-block zeroes it along with the other outputs; abort in
    // IDLE leaves a finished block's count visible.
    always_comb begin
        cnt_d = cnt_q;
        if (bus.abort) begin
            if (state_q != StIdle) begin
                cnt_d = '0;
            end
        end else if (state_q == StClr) begin
            cnt_d = '0;
        end else if (state_q == StUpd) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.smp_ready = smp_ready;
    assign bus.x_ld      = x_ld;
    assign bus.st_clr    = st_clr;
    assign bus.mul_en    = mul_en;
    assign bus.add_en    = add_en;
    assign bus.st_upd    = st_upd;
    assign bus.busy      = busy;
    assign bus.smp_cnt   = cnt_q;
    assign bus.res_valid = res_valid;

endmodule
